// File: rtl/box_target_tx.sv
// Game-side target transmitter for the Arduino box link: picks a pseudo-random
// box each round, hands it over with a 4-phase strobe/ack, and scores the hit.
module box_target_tx #(
  parameter int unsigned ROUND_CYCLES = 75_000_000,
  parameter int unsigned ACK_TIMEOUT  = 50_000,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start_game,
  input  logic [2:0] box_address,
  input  logic       gpio_ack,
  output logic [2:0] gpio_tgt,
  output logic       gpio_stb,
  output logic [2:0] level_select,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [7:0] hit_count,
  output logic       busy,
  output logic       link_err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PICK     = 3'd1;
  localparam logic [2:0] S_SEND     = 3'd2;
  localparam logic [2:0] S_WAIT_ACK = 3'd3;
  localparam logic [2:0] S_WAIT_REL = 3'd4;
  localparam logic [2:0] S_ARMED    = 3'd5;

  localparam int RW = $clog2(ROUND_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [RW-1:0] ROUND_LAST = RW'(ROUND_CYCLES - 1);
  localparam logic [TW-1:0] ACK_LAST   = TW'(ACK_TIMEOUT - 1);

  logic [2:0]    state_reg, state_next;
  logic [7:0]    lfsr_reg;
  logic [2:0]    target_reg, prev_tgt_reg;
  logic [1:0]    ack_sync_reg;
  logic [2:0]    box_q_reg, b_prev_reg;
  logic [RW-1:0] round_cnt_reg;
  logic [TW-1:0] to_cnt_reg;
  logic          hit_pulse_reg, miss_pulse_reg, link_err_reg;
  logic [7:0]    hit_count_reg;

  logic       ack_s;
  logic [7:0] lfsr_next;
  logic [2:0] lfsr_mod6, tgt_raw, tgt_pick;
  logic       hit_next, miss_next, link_set_next;

  assign ack_s     = ack_sync_reg[1];
  assign lfsr_next = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};

  // Boxes are numbered 1..6; never repeat the previous target back to back.
  assign lfsr_mod6 = (lfsr_next[2:0] >= 3'd6) ? (lfsr_next[2:0] - 3'd6) : lfsr_next[2:0];
  assign tgt_raw   = lfsr_mod6 + 3'd1;
  assign tgt_pick  = (tgt_raw != prev_tgt_reg) ? tgt_raw :
                     (tgt_raw == 3'd6)         ? 3'd1    : (tgt_raw + 3'd1);

  always_comb begin
    state_next    = state_reg;
    hit_next      = 1'b0;
    miss_next     = 1'b0;
    link_set_next = 1'b0;
    case (state_reg)
      S_IDLE:     if (start_game && !link_err_reg) state_next = S_PICK;
      S_PICK:     state_next = S_SEND;
      S_SEND:     state_next = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (ack_s) begin
          state_next = S_WAIT_REL;
        end else if (to_cnt_reg == ACK_LAST) begin
          state_next    = S_IDLE;
          link_set_next = 1'b1;
        end
      end
      S_WAIT_REL: begin
        if (!ack_s) begin
          state_next = S_ARMED;
        end else if (to_cnt_reg == ACK_LAST) begin
          state_next    = S_IDLE;
          link_set_next = 1'b1;
        end
      end
      S_ARMED: begin
        if (box_q_reg == target_reg) begin
          hit_next   = 1'b1;
          state_next = S_PICK;
        end else if (round_cnt_reg == ROUND_LAST) begin
          miss_next  = 1'b1;
          state_next = S_PICK;
        end else if (box_q_reg != 3'd0 && box_q_reg != b_prev_reg) begin
          miss_next  = 1'b1;
        end
      end
      default:    state_next = S_IDLE;
    endcase
    // Stopping the game overrides everything, including a pending score.
    if (!start_game && state_reg != S_IDLE) begin
      state_next    = S_IDLE;
      hit_next      = 1'b0;
      miss_next     = 1'b0;
      link_set_next = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      lfsr_reg       <= LFSR_SEED;
      target_reg     <= 3'd0;
      prev_tgt_reg   <= 3'd0;
      ack_sync_reg   <= 2'b00;
      box_q_reg      <= 3'd0;
      b_prev_reg     <= 3'd0;
      round_cnt_reg  <= '0;
      to_cnt_reg     <= '0;
      hit_pulse_reg  <= 1'b0;
      miss_pulse_reg <= 1'b0;
      hit_count_reg  <= 8'd0;
      link_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ack_sync_reg   <= {ack_sync_reg[0], gpio_ack};
      box_q_reg      <= box_address;
      b_prev_reg     <= box_q_reg;
      hit_pulse_reg  <= hit_next;
      miss_pulse_reg <= miss_next;
      if (link_set_next) link_err_reg <= 1'b1;
      if (state_reg == S_PICK) begin
        lfsr_reg     <= lfsr_next;
        target_reg   <= tgt_pick;
        prev_tgt_reg <= tgt_pick;
      end
      // Handshake timer restarts on every state change.
      if (state_next != state_reg)
        to_cnt_reg <= '0;
      else if (state_reg == S_WAIT_ACK || state_reg == S_WAIT_REL)
        to_cnt_reg <= to_cnt_reg + TW'(1);
      if (state_reg != S_ARMED)
        round_cnt_reg <= '0;
      else
        round_cnt_reg <= round_cnt_reg + RW'(1);
      if (hit_next && hit_count_reg != 8'hFF)
        hit_count_reg <= hit_count_reg + 8'd1;
      else if (!start_game && state_next == S_IDLE)
        hit_count_reg <= 8'd0;
    end
  end

  always_comb begin
    gpio_stb     = (state_reg == S_WAIT_ACK);
    gpio_tgt     = (state_reg == S_SEND || state_reg == S_WAIT_ACK ||
                    state_reg == S_WAIT_REL || state_reg == S_ARMED) ? target_reg : 3'd0;
    level_select = (state_reg == S_ARMED) ? target_reg : 3'd0;
    busy         = (state_reg != S_IDLE);
  end

  assign hit_pulse  = hit_pulse_reg;
  assign miss_pulse = miss_pulse_reg;
  assign hit_count  = hit_count_reg;
  assign link_err   = link_err_reg;

endmodule
